// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage encodings: access sizes, control-word layout, FSM states, byte enables.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       uns;
    logic [1:0] size;
  } mem_ctrl_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_e;

  // Size encoding 2'b11 is treated as a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SZ_HALF) && a[0]) || (size[1] && (a != 2'b00));
  endfunction

  function automatic logic [1:0] align_mask(input logic [1:0] size);
    if (size == SZ_BYTE) return 2'b11;
    if (size == SZ_HALF) return 2'b10;
    return 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface mem_access_if #(
  parameter int ADDR_W = 32
);
  logic              dm_req;
  logic              dm_wr;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_addr_ok;
  logic              dm_data_ok;
  logic [31:0]       dm_rdata;

  modport master (
    output dm_req, dm_wr, dm_be, dm_addr, dm_wdata,
    input  dm_addr_ok, dm_data_ok, dm_rdata
  );

  modport slave (
    input  dm_req, dm_wr, dm_be, dm_addr, dm_wdata,
    output dm_addr_ok, dm_data_ok, dm_rdata
  );
endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering for stores (enables, replicated data) and lane select plus extension for loads.
module load_store_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(rdata >> {addr_lo, 3'b000});
    half_lane = 16'(rdata >> {addr_lo[1], 4'b0000});
    be        = BE_WORD;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SZ_BYTE: begin
        be        = BE_BYTE << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_lane[7] & ~uns}}, byte_lane};
      end
      SZ_HALF: begin
        be        = BE_HALF << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_lane[15] & ~uns}}, half_lane};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access.sv
// MEM stage: sequences one data-memory access per load/store and registers results toward write-back.
// Define MEM_UNALIGNED_EXC_EN to raise address-error flags on misaligned half/word accesses.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass straight to wb_*
// REQ   | dm_req asserted with held address/data, waiting for dm_addr_ok
// WAIT  | request accepted, waiting for dm_data_ok
// DONE  | read data buffered; loads wb_* once stall_in is low
module mem_access
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_in,
  input  logic         ex_valid,
  input  logic [31:0]  ex_inst,
  input  logic [31:0]  ex_alu_result,
  input  logic [31:0]  ex_store_data,
  input  logic [4:0]   ex_write_addr,
  input  logic         ex_reg_write,
  input  logic [4:0]   ex_mem_ctrl,
  output logic         mem_stall,
  mem_access_if.master dm,
  output logic         wb_valid,
  output logic [31:0]  wb_inst,
  output logic [4:0]   wb_write_addr,
  output logic [31:0]  wb_write_data,
  output logic         wb_reg_write,
  output logic         exc_adel,
  output logic         exc_ades
);
  mem_state_e  state;
  mem_ctrl_t   ex_ctrl;
  mem_ctrl_t   h_ctrl;
  logic [31:0] h_inst;
  logic [31:0] h_alu;
  logic [4:0]  h_wa;
  logic        h_rw;
  logic [31:0] rbuf;

  logic        ex_memop;
  logic        ex_fault;
  logic        ex_go;
  logic [31:0] ex_addr;

  logic        al_sel_ex;
  logic [1:0]  al_addr;
  logic [1:0]  al_size;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign ex_ctrl  = mem_ctrl_t'(ex_mem_ctrl);
  assign ex_memop = ex_valid && (ex_ctrl.rd || ex_ctrl.wr);

`ifdef MEM_UNALIGNED_EXC_EN
  assign ex_fault = ex_memop && misaligned(ex_ctrl.size, ex_alu_result[1:0]);
  assign ex_addr  = ex_alu_result;
`else
  assign ex_fault = 1'b0;
  assign ex_addr  = {ex_alu_result[31:2], ex_alu_result[1:0] & align_mask(ex_ctrl.size)};
`endif

  assign ex_go = ex_memop && !ex_fault;

  assign mem_stall = (state == REQ) || (state == WAIT) ||
                     ((state == DONE) && stall_in) ||
                     ((state == IDLE) && ex_go);

  // Store lanes are computed from the EX fields at capture; load lanes from the held fields.
  assign al_sel_ex = (state == IDLE);
  assign al_addr   = al_sel_ex ? ex_addr[1:0] : h_alu[1:0];
  assign al_size   = al_sel_ex ? ex_ctrl.size : h_ctrl.size;
  assign al_uns    = al_sel_ex ? ex_ctrl.uns  : h_ctrl.uns;

  load_store_align u_align (
    .addr_lo    (al_addr),
    .size       (al_size),
    .uns        (al_uns),
    .store_data (ex_store_data),
    .rdata      (rbuf),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      h_ctrl        <= '0;
      h_inst        <= '0;
      h_alu         <= '0;
      h_wa          <= '0;
      h_rw          <= 1'b0;
      rbuf          <= '0;
      dm.dm_req     <= 1'b0;
      dm.dm_wr      <= 1'b0;
      dm.dm_be      <= '0;
      dm.dm_addr    <= '0;
      dm.dm_wdata   <= '0;
      wb_valid      <= 1'b0;
      wb_inst       <= '0;
      wb_write_addr <= '0;
      wb_write_data <= '0;
      wb_reg_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ex_go) begin
          h_ctrl      <= ex_ctrl;
          h_inst      <= ex_inst;
          h_alu       <= ex_alu_result;
          h_wa        <= ex_write_addr;
          h_rw        <= ex_reg_write;
          dm.dm_req   <= 1'b1;
          dm.dm_wr    <= ex_ctrl.wr;
          dm.dm_be    <= al_be;
          dm.dm_addr  <= ADDR_W'(ex_addr);
          dm.dm_wdata <= al_wdata;
          state       <= REQ;
        end
        REQ: if (dm.dm_addr_ok) begin
          dm.dm_req <= 1'b0;
          if (dm.dm_data_ok) begin
            rbuf  <= dm.dm_rdata;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (dm.dm_data_ok) begin
          rbuf  <= dm.dm_rdata;
          state <= DONE;
        end
        DONE: if (!stall_in) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!stall_in) begin
        if (state == DONE) begin
          wb_valid      <= 1'b1;
          wb_inst       <= h_inst;
          wb_write_addr <= h_wa;
          wb_write_data <= h_ctrl.wr ? h_alu : al_load;
          wb_reg_write  <= h_rw && h_ctrl.rd && !h_ctrl.wr && (h_wa != 5'd0);
        end else if ((state == IDLE) && ex_valid && !ex_go) begin
          wb_valid      <= 1'b1;
          wb_inst       <= ex_inst;
          wb_write_addr <= ex_write_addr;
          wb_write_data <= ex_alu_result;
          wb_reg_write  <= ex_reg_write && !ex_fault && (ex_write_addr != 5'd0);
        end else begin
          wb_valid      <= 1'b0;
          wb_reg_write  <= 1'b0;
        end
      end
    end
  end

`ifdef MEM_UNALIGNED_EXC_EN
  // A faulting op is only ever retired from IDLE, so the flags track that path alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
    end else if (!stall_in) begin
      exc_adel <= (state == IDLE) && ex_fault && !ex_ctrl.wr;
      exc_ades <= (state == IDLE) && ex_fault && ex_ctrl.wr;
    end
  end
`else
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

endmodule
